// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional rotate-left support is enabled with SHIFTER_ROTATE_EN.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_t;

    localparam int DEF_WIDTH = 32;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered level of the barrel shifter: shifts by DIST when its shamt bit is set.
// With SHIFTER_ROTATE_EN defined, OP_ROL rotates; otherwise it behaves as SLL.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DIST    = 1,
    parameter int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               advance_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    input  shift_op_t          op_i,
    input  logic               sign_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output shift_op_t          op_o,
    output logic               sign_o,
    output logic [SHAMT_W-1:0] shamt_o
);

    localparam int BIT = $clog2(DIST);

    logic               valid_q;
    logic [WIDTH-1:0]   data_q, data_d, shifted;
    shift_op_t          op_q;
    logic               sign_q;
    logic [SHAMT_W-1:0] shamt_q;

    always_comb begin
        shifted = data_i;
        unique case (op_i)
`ifdef SHIFTER_ROTATE_EN
            OP_SLL: shifted = data_i << DIST;
            OP_ROL: shifted = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
`else
            OP_SLL, OP_ROL: shifted = data_i << DIST;
`endif
            OP_SRL: shifted = data_i >> DIST;
            // sign is the original operand MSB, carried from the first stage
            OP_SRA: shifted = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        endcase
        data_d = shamt_i[BIT] ? shifted : data_i;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= OP_SLL;
            sign_q  <= 1'b0;
            shamt_q <= '0;
        end else if (advance_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            op_q    <= op_i;
            sign_q  <= sign_i;
            shamt_q <= shamt_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign op_o    = op_q;
    assign sign_o  = sign_q;
    assign shamt_o = shamt_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter, one register stage per shift-amount bit, largest first.
// Define SHIFTER_ROTATE_EN to make op 11 a rotate-left instead of an SLL alias.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    logic               advance;
    logic               v  [SHAMT_W+1];
    logic [WIDTH-1:0]   d  [SHAMT_W+1];
    shift_op_t          o  [SHAMT_W+1];
    logic               s  [SHAMT_W+1];
    logic [SHAMT_W-1:0] sh [SHAMT_W+1];
    logic               unused_tail;

    // the whole pipe moves in lockstep; bubbles are never squeezed out
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign v[0]  = in_valid;
    assign d[0]  = in_data;
    assign o[0]  = shift_op_t'(in_op);
    assign s[0]  = in_data[WIDTH-1];
    assign sh[0] = in_shamt;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH   (WIDTH),
            .DIST    (1 << (SHAMT_W - 1 - k)),
            .SHAMT_W (SHAMT_W)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .advance_i (advance),
            .valid_i   (v[k]),
            .data_i    (d[k]),
            .op_i      (o[k]),
            .sign_i    (s[k]),
            .shamt_i   (sh[k]),
            .valid_o   (v[k+1]),
            .data_o    (d[k+1]),
            .op_o      (o[k+1]),
            .sign_o    (s[k+1]),
            .shamt_o   (sh[k+1])
        );
    end

    assign out_valid   = v[SHAMT_W];
    assign out_data    = d[SHAMT_W];
    assign unused_tail = ^{s[SHAMT_W], o[SHAMT_W], sh[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=32) with a transaction-level model.
// Rotate expectations follow SHIFTER_ROTATE_EN.
module tb_pipelined_shifter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    logic [31:0] expq[$];

    pipelined_shifter #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] x,
                                          input int sa);
        logic [63:0] wide;
        case (op)
            2'b00: return x << sa;
            2'b01: return x >> sa;
            2'b10: return 32'($signed(x) >>> sa);
            default: begin
`ifdef SHIFTER_ROTATE_EN
                wide = {x, x} << sa;
                return wide[63:32];
`else
                wide = '0;
                return x << sa;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at negedge with inputs already driven; returns at next negedge
    task automatic tick();
        logic        stall;
        logic [31:0] held;
        #1;
        if (out_valid && out_ready) begin
            delivered++;
            if (expq.size() == 0) chk("spurious_out", out_data, 32'hx);
            else chk("sb_data", out_data, expq.pop_front());
        end
        if (in_valid && in_ready)
            expq.push_back(model(in_op, in_data, int'(in_shamt)));
        stall = out_valid && !out_ready;
        held  = out_data;
        @(posedge clock);
        @(negedge clock);
        if (stall) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_data", out_data, held);
        end
    endtask

    task automatic single(input logic [1:0] op, input logic [31:0] x,
                          input logic [4:0] sa, input logic [31:0] exp,
                          input string tag);
        int n;
        in_valid = 1'b1; in_op = op; in_data = x; in_shamt = sa;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd5);
        chk(tag, out_data, exp);
        tick();
    endtask

    initial begin
        int n;
        int base;
        logic [31:0] rot_exp;

        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);

        single(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll31");

        // SRL then SRA back to back
        in_valid = 1'b1; in_data = 32'h8000_0000; in_shamt = 5'd4;
        in_op = 2'b01;
        tick();
        in_op = 2'b10;
        tick();
        in_valid = 1'b0;
        n = 2;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("srl_lat", 32'(n), 32'd5);
        chk("srl4", out_data, 32'h0800_0000);
        tick();
        chk("sra_valid", {31'b0, out_valid}, 32'd1);
        chk("sra4", out_data, 32'hF800_0000);
        tick();

        // stream of 8 SLLs with a 3-cycle output stall
        base = delivered;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_op = 2'b00; in_data = 32'd1; in_shamt = 5'(i);
            tick();
        end
        in_shamt = 5'd6;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_shamt = 5'd7;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("stream_drain", 32'(expq.size()), 32'd0);
        chk("stream_count", 32'(delivered - base), 32'd8);

        for (int m = 0; m < 4; m++)
            single(2'(m), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, "shamt0");

`ifdef SHIFTER_ROTATE_EN
        rot_exp = 32'h0000_0003;
`else
        rot_exp = 32'h0000_0002;
`endif
        single(2'b11, 32'h8000_0001, 5'd1, rot_exp, "op11");

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 2'b00; in_data = 32'hFFFF_FFFF;
            in_shamt = 5'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd1);
        expq.delete();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("no_stale", {31'b0, out_valid}, 32'd0);
        end

        // randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_op     = 2'($urandom);
            in_data   = $urandom;
            in_shamt  = 5'($urandom);
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("rand_drain", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
